mem_port_arbiter: RTL and testbench

Single-port access scheduler for the 16 x 4-bit register memory, shared between the CPU control unit (read/write), the UART programmer (write-only) and a debug readback port (read-only). It sits between these three requesters and the memory's address/data/write-enable inputs. It serialises their requests, locks the CPU out while programming mode is active, and issues a CPU restart pulse once programming ends. Debug reads cannot be starved.

---
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port scheduler for the register memory. Serialises programmer writes,
// CPU accesses and debug reads. Locks the CPU out during programming and
// pulses a restart once programming has ended. Debug reads cannot be starved.
module mem_port_arbiter #(
    parameter int unsigned REGISTER_WIDTH          = 4,
    parameter int unsigned MEMORY_ADDRESS_WIDTH    = 4,
    parameter int unsigned STARVE_LIMIT            = 4,
    parameter int unsigned STARVE_COUNTER_BITWIDTH = 3
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            prog_mode_i,
    input  logic                            prog_req_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] prog_addr_i,
    input  logic [REGISTER_WIDTH-1:0]       prog_wdata_i,
    output logic                            prog_gnt_o,
    output logic                            prog_err_o,
    input  logic                            cpu_req_i,
    input  logic                            cpu_we_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] cpu_addr_i,
    input  logic [REGISTER_WIDTH-1:0]       cpu_wdata_i,
    output logic                            cpu_gnt_o,
    output logic                            cpu_rvalid_o,
    output logic [REGISTER_WIDTH-1:0]       cpu_rdata_o,
    output logic                            cpu_hold_o,
    output logic                            cpu_restart_o,
    input  logic                            dbg_req_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] dbg_addr_i,
    output logic                            dbg_gnt_o,
    output logic                            dbg_rvalid_o,
    output logic [REGISTER_WIDTH-1:0]       dbg_rdata_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [REGISTER_WIDTH-1:0]       mem_wdata_o,
    output logic                            mem_we_o,
    input  logic [REGISTER_WIDTH-1:0]       mem_rdata_i
);

    typedef enum logic {StIdle, StAccess} state_e;
    typedef enum logic [1:0] {OwnProg, OwnCpu, OwnDbg} owner_e;

    localparam logic [STARVE_COUNTER_BITWIDTH-1:0] StarveMax =
        STARVE_COUNTER_BITWIDTH'(STARVE_LIMIT);
    localparam logic [STARVE_COUNTER_BITWIDTH-1:0] StarveOne =
        STARVE_COUNTER_BITWIDTH'(1);

    state_e                            state_q, state_d;
    owner_e                            owner_q, owner_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [REGISTER_WIDTH-1:0]         wdata_q, wdata_d;
    logic                              we_q, we_d;
    logic [STARVE_COUNTER_BITWIDTH-1:0] starve_q, starve_d;
    logic                              hold_q, hold_d;
    logic                              drain_q, drain_d;
    logic                              restart_q, restart_d;
    logic                              err_q, err_d;
    logic                              cpu_rvalid_q, cpu_rvalid_d;
    logic                              dbg_rvalid_q, dbg_rvalid_d;
    logic [REGISTER_WIDTH-1:0]         cpu_rdata_q, cpu_rdata_d;
    logic [REGISTER_WIDTH-1:0]         dbg_rdata_q, dbg_rdata_d;

    logic prog_elig, cpu_elig, dbg_elig, dbg_force, grant;
    logic access;

    assign prog_elig = prog_req_i && prog_mode_i;
    assign cpu_elig  = cpu_req_i && !hold_q;
    assign dbg_elig  = dbg_req_i;
    assign dbg_force = dbg_elig && (starve_q == StarveMax);

    // Next-state: arbitration, access completion, starvation and CPU lock.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        starve_d     = starve_q;
        hold_d       = hold_q;
        drain_d      = drain_q;
        restart_d    = 1'b0;
        err_d        = err_q | (prog_req_i & ~prog_mode_i);
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        grant        = 1'b0;

        case (state_q)
            StIdle: begin
                if (prog_elig || cpu_elig || dbg_elig) begin
                    state_d = StAccess;
                    grant   = 1'b1;
                    if (dbg_force) begin
                        owner_d = OwnDbg;
                        addr_d  = dbg_addr_i;
                        we_d    = 1'b0;
                    end else if (prog_elig) begin
                        owner_d = OwnProg;
                        addr_d  = prog_addr_i;
                        wdata_d = prog_wdata_i;
                        we_d    = 1'b1;
                    end else if (cpu_elig) begin
                        owner_d = OwnCpu;
                        addr_d  = cpu_addr_i;
                        wdata_d = cpu_wdata_i;
                        we_d    = cpu_we_i;
                    end else begin
                        owner_d = OwnDbg;
                        addr_d  = dbg_addr_i;
                        we_d    = 1'b0;
                    end
                end
            end
            StAccess: begin
                state_d = StIdle;
                if (!we_q) begin
                    if (owner_q == OwnCpu) begin
                        cpu_rvalid_d = 1'b1;
                        cpu_rdata_d  = mem_rdata_i;
                    end else if (owner_q == OwnDbg) begin
                        dbg_rvalid_d = 1'b1;
                        dbg_rdata_d  = mem_rdata_i;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Counts grants that debug lost while it was waiting.
        if (!dbg_req_i) begin
            starve_d = '0;
        end else if (grant) begin
            if (owner_d == OwnDbg) begin
                starve_d = '0;
            end else if (starve_q != StarveMax) begin
                starve_d = starve_q + StarveOne;
            end
        end

        // Lock stays up until the arbiter is idle, then restart and release together.
        if (prog_mode_i) begin
            hold_d  = 1'b1;
            drain_d = 1'b0;
        end else if (hold_q || drain_q) begin
            if (state_d == StIdle) begin
                hold_d    = 1'b0;
                drain_d   = 1'b0;
                restart_d = 1'b1;
            end else begin
                hold_d  = 1'b1;
                drain_d = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= StIdle;
            owner_q      <= OwnProg;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            starve_q     <= '0;
            hold_q       <= 1'b0;
            drain_q      <= 1'b0;
            restart_q    <= 1'b0;
            err_q        <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            starve_q     <= starve_d;
            hold_q       <= hold_d;
            drain_q      <= drain_d;
            restart_q    <= restart_d;
            err_q        <= err_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Reset asserted during an access suppresses its grant and write.
    assign access        = (state_q == StAccess) && reset_i;
    assign prog_gnt_o    = access && (owner_q == OwnProg);
    assign cpu_gnt_o     = access && (owner_q == OwnCpu);
    assign dbg_gnt_o     = access && (owner_q == OwnDbg);
    assign mem_we_o      = access && we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign prog_err_o    = err_q;
    assign cpu_hold_o    = hold_q;
    assign cpu_restart_o = restart_q;
    assign cpu_rvalid_o  = cpu_rvalid_q;
    assign cpu_rdata_o   = cpu_rdata_q;
    assign dbg_rvalid_o  = dbg_rvalid_q;
    assign dbg_rdata_o   = dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int Limit = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       prog_mode = 1'b0, prog_req = 1'b0;
    logic [3:0] prog_addr = '0, prog_wdata = '0;
    logic       prog_gnt, prog_err;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [3:0] cpu_addr = '0, cpu_wdata = '0;
    logic       cpu_gnt, cpu_rvalid, cpu_hold, cpu_restart;
    logic [3:0] cpu_rdata;
    logic       dbg_req = 1'b0;
    logic [3:0] dbg_addr = '0;
    logic       dbg_gnt, dbg_rvalid;
    logic [3:0] dbg_rdata;
    logic [3:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    int total = 0;
    int bad = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .REGISTER_WIDTH          (4),
        .MEMORY_ADDRESS_WIDTH    (4),
        .STARVE_LIMIT            (Limit),
        .STARVE_COUNTER_BITWIDTH (3)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_n),
        .prog_mode_i   (prog_mode),
        .prog_req_i    (prog_req),
        .prog_addr_i   (prog_addr),
        .prog_wdata_i  (prog_wdata),
        .prog_gnt_o    (prog_gnt),
        .prog_err_o    (prog_err),
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_gnt_o     (cpu_gnt),
        .cpu_rvalid_o  (cpu_rvalid),
        .cpu_rdata_o   (cpu_rdata),
        .cpu_hold_o    (cpu_hold),
        .cpu_restart_o (cpu_restart),
        .dbg_req_i     (dbg_req),
        .dbg_addr_i    (dbg_addr),
        .dbg_gnt_o     (dbg_gnt),
        .dbg_rvalid_o  (dbg_rvalid),
        .dbg_rdata_o   (dbg_rdata),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_we_o      (mem_we),
        .mem_rdata_i   (mem_rdata)
    );

    // Register memory: word i starts as i ^ 9, so word 3 = A and word 6 = F.
    logic [3:0] mem [16];
    bit mem_ready = 0;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i) ^ 4'h9;
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expectations describe the cycle that begins at the edge just processed.
    bit         e_busy = 0, e_we = 0;
    int         e_who = 0;             // 0 prog, 1 cpu, 2 dbg
    logic [3:0] e_addr = '0, e_wdata = '0;
    bit         e_cpu_rv = 0, e_dbg_rv = 0;
    logic [3:0] e_cpu_rd = '0, e_dbg_rd = '0;
    bit         e_hold = 0, e_restart = 0, e_err = 0;
    int         starve = 0;
    logic [3:0] shadow [16];
    bit         shadow_ready = 0;

    always @(posedge clk) begin : model
        bit was_busy;
        bit locked;
        bit want [3];
        int winner;
        if (!shadow_ready) begin
            for (int i = 0; i < 16; i++) shadow[i] = 4'(i) ^ 4'h9;
            shadow_ready = 1;
        end
        if (!reset_n) begin
            e_busy = 0; e_we = 0; e_addr = '0; e_wdata = '0;
            e_cpu_rv = 0; e_dbg_rv = 0; e_cpu_rd = '0; e_dbg_rd = '0;
            e_hold = 0; e_restart = 0; e_err = 0; starve = 0;
        end else begin
            was_busy  = e_busy;
            locked    = e_hold;
            e_cpu_rv  = 0;
            e_dbg_rv  = 0;
            e_restart = 0;
            if (prog_req && !prog_mode) e_err = 1;
            if (was_busy) begin
                if (e_we) shadow[e_addr] = e_wdata;
                else if (e_who == 1) begin e_cpu_rv = 1; e_cpu_rd = shadow[e_addr]; end
                else begin e_dbg_rv = 1; e_dbg_rd = shadow[e_addr]; end
                e_busy = 0;
            end else begin
                want[0] = prog_req && prog_mode;
                want[1] = cpu_req && !locked;
                want[2] = dbg_req;
                winner = -1;
                if (want[2] && starve >= Limit) winner = 2;
                else if (want[0]) winner = 0;
                else if (want[1]) winner = 1;
                else if (want[2]) winner = 2;
                if (winner >= 0) begin
                    e_busy = 1;
                    e_who  = winner;
                    case (winner)
                        0: begin e_addr = prog_addr; e_wdata = prog_wdata; e_we = 1; end
                        1: begin e_addr = cpu_addr; e_wdata = cpu_wdata; e_we = cpu_we; end
                        default: begin e_addr = dbg_addr; e_we = 0; end
                    endcase
                    if (dbg_req) starve = (winner == 2) ? 0 : ((starve < Limit) ? starve + 1 : starve);
                end
            end
            if (!dbg_req) starve = 0;
            if (prog_mode) e_hold = 1;
            else if (locked && !e_busy) begin
                e_hold = 0;
                e_restart = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            bit acc;
            acc = e_busy && reset_n;
            chk("prog_gnt", prog_gnt, acc && e_who == 0);
            chk("cpu_gnt", cpu_gnt, acc && e_who == 1);
            chk("dbg_gnt", dbg_gnt, acc && e_who == 2);
            chk("mem_we", mem_we, acc && e_we);
            chk("mem_addr", mem_addr, e_addr);
            if (acc && e_we) chk("mem_wdata", mem_wdata, e_wdata);
            chk("cpu_rvalid", cpu_rvalid, e_cpu_rv);
            chk("cpu_rdata", cpu_rdata, e_cpu_rd);
            chk("dbg_rvalid", dbg_rvalid, e_dbg_rv);
            chk("dbg_rdata", dbg_rdata, e_dbg_rd);
            chk("cpu_hold", cpu_hold, e_hold);
            chk("cpu_restart", cpu_restart, e_restart);
            chk("prog_err", prog_err, e_err);
        end
    end

    // Grant seen in the cycle that just ended, used by the random requesters.
    bit g_prog = 0, g_cpu = 0, g_dbg = 0;
    always @(negedge clk) begin
        g_prog <= prog_gnt;
        g_cpu  <= cpu_gnt;
        g_dbg  <= dbg_gnt;
    end

    // ---------------- stimulus ----------------
    initial begin
        int  n_cpu;
        bit  seen;

        // Reset.
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        checking = 1;
        @(negedge clk);
        chk("rst_gnts", {prog_gnt, cpu_gnt, dbg_gnt}, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_err", prog_err, 0);

        // CPU read of word 3.
        @(posedge clk); #1 cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
        @(negedge clk); chk("rd3_no_gnt_yet", cpu_gnt, 0);
        @(negedge clk);
        chk("rd3_gnt", cpu_gnt, 1);
        chk("rd3_addr", mem_addr, 4'h3);
        chk("rd3_we", mem_we, 0);
        @(posedge clk); #1 cpu_req = 0;
        @(negedge clk);
        chk("rd3_rvalid", cpu_rvalid, 1);
        chk("rd3_rdata", cpu_rdata, 4'hA);
        @(negedge clk); chk("rd3_rvalid_once", cpu_rvalid, 0);

        // Programming write to F with the CPU requesting, then drop mode mid-access.
        @(posedge clk); #1 prog_mode = 1;
        @(posedge clk); #1 prog_req = 1; prog_addr = 4'hF; prog_wdata = 4'h5;
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'hF;
        @(negedge clk);
        chk("lock_hold", cpu_hold, 1);
        chk("lock_no_cpu_gnt", cpu_gnt, 0);
        @(negedge clk);
        chk("pw_gnt", prog_gnt, 1);
        chk("pw_no_cpu_gnt", cpu_gnt, 0);
        chk("pw_we", mem_we, 1);
        chk("pw_addr", mem_addr, 4'hF);
        chk("pw_wdata", mem_wdata, 4'h5);
        #1 prog_mode = 0; prog_req = 0;
        @(negedge clk);
        chk("restart_pulse", cpu_restart, 1);
        chk("restart_hold_low", cpu_hold, 0);
        chk("restart_no_cpu_gnt", cpu_gnt, 0);
        @(negedge clk);
        chk("restart_once", cpu_restart, 0);
        chk("rdF_gnt", cpu_gnt, 1);
        @(posedge clk); #1 cpu_req = 0;
        @(negedge clk);
        chk("rdF_rvalid", cpu_rvalid, 1);
        chk("rdF_rdata", cpu_rdata, 4'h5);

        // Starvation: continuous CPU reads versus a held debug read.
        @(posedge clk); #1 cpu_req = 1; cpu_we = 0; cpu_addr = 4'h1; dbg_req = 1; dbg_addr = 4'h2;
        for (int round = 0; round < 2; round++) begin
            n_cpu = 0;
            seen = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (cpu_gnt) n_cpu++;
                if (dbg_gnt) seen = 1;
            end
            chk("starve_dbg_granted", seen, 1);
            chk("starve_cpu_grants", n_cpu, 4);
        end
        @(posedge clk); #1 cpu_req = 0; dbg_req = 0;

        // Programmer request outside programming mode.
        @(posedge clk); #1 prog_req = 1; prog_addr = 4'h4; prog_wdata = 4'h3;
        @(negedge clk); chk("err_not_yet", prog_err, 0);
        repeat (3) begin
            @(negedge clk);
            chk("err_set", prog_err, 1);
            chk("err_no_gnt", prog_gnt, 0);
        end
        @(posedge clk); #1 prog_req = 0;
        repeat (2) @(negedge clk);
        chk("err_sticky", prog_err, 1);

        // Reset during a CPU write to word 6.
        @(posedge clk); #1 cpu_req = 1; cpu_we = 1; cpu_addr = 4'h6; cpu_wdata = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("wr6_gnt", cpu_gnt, 1);
        #1 reset_n = 0; cpu_req = 0;
        #1 chk("wr6_abort_we", mem_we, 0);
        chk("wr6_abort_gnt", cpu_gnt, 0);
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk);
        chk("wr6_mem_kept", mem[6], 4'hF);
        chk("wr6_rst_outs", {cpu_gnt, mem_we, cpu_hold, cpu_restart, cpu_rvalid, prog_err}, 0);
        chk("wr6_rst_addr", mem_addr, 0);
        chk("wr6_rst_rdata", cpu_rdata, 0);

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            reset_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 39) == 0) begin
                prog_mode = !prog_mode;
                if (!prog_mode) prog_req = 0;
            end
            if (prog_req) begin
                if (g_prog) begin
                    if ($urandom_range(0, 1) == 1) begin
                        prog_addr = 4'($urandom); prog_wdata = 4'($urandom);
                    end else prog_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0 && (prog_mode || $urandom_range(0, 99) == 0)) begin
                prog_req = 1; prog_addr = 4'($urandom); prog_wdata = 4'($urandom);
            end
            if (cpu_req) begin
                if (g_cpu) begin
                    if ($urandom_range(0, 1) == 1) begin
                        cpu_we = 1'($urandom); cpu_addr = 4'($urandom); cpu_wdata = 4'($urandom);
                    end else cpu_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 4'($urandom); cpu_wdata = 4'($urandom);
            end
            if (dbg_req) begin
                if (g_dbg) begin
                    if ($urandom_range(0, 1) == 1) dbg_addr = 4'($urandom);
                    else dbg_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dbg_req = 1; dbg_addr = 4'($urandom);
            end
        end
        @(posedge clk); #1 reset_n = 1;
        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
